// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman engine: FSM state encoding and the
// default word length, mistake limit and character width.
package hangman_pkg;

  localparam int unsigned WORD_LEN_DEF     = 5;
  localparam int unsigned MAX_MISTAKES_DEF = 6;
  localparam int unsigned CHAR_W_DEF       = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_GUESS = 3'd1,
    ST_SCAN       = 3'd2,
    ST_UPDATE     = 3'd3,
    ST_WIN        = 3'd4,
    ST_LOSE       = 3'd5
  } state_t;

endpackage

// File: rtl/letter_scanner.sv
// Sequential letter comparator: after start, compares guess against one
// letter of word per cycle (letter 0 first) and accumulates a match mask.
// Ports:
//   clk, rst     - clock, async active-high reset
//   clr          - synchronous abort (drops any scan in progress)
//   start        - begin a new scan on the next cycle
//   word, guess  - secret word (letter 0 in MSBs) and guessed character
//   done         - high during the last compare cycle
//   mask         - match mask including the current compare (final when done)
module letter_scanner #(
  parameter int unsigned WORD_LEN = 5,
  parameter int unsigned CHAR_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         start,
  input  logic [WORD_LEN*CHAR_W-1:0]   word,
  input  logic [CHAR_W-1:0]            guess,
  output logic                         done,
  output logic [WORD_LEN-1:0]          mask
);

  localparam int unsigned IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  logic                active_q, active_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_LEN-1:0] mask_q, mask_d;
  logic [CHAR_W-1:0]   letter_c;
  logic                match_c;

  // Select the letter under the index; letter 0 sits in the MSBs.
  always_comb begin
    letter_c = '0;
    for (int i = 0; i < int'(WORD_LEN); i++) begin
      if (idx_q == IDX_W'(i)) begin
        letter_c = word[(int'(WORD_LEN) - 1 - i) * int'(CHAR_W) +: CHAR_W];
      end
    end
  end

  assign match_c = active_q && (letter_c == guess);
  assign done    = active_q && (idx_q == IDX_W'(WORD_LEN - 1));
  assign mask    = mask_q | (match_c ? (WORD_LEN'(1) << idx_q) : '0);

  // Index counter and mask accumulator.
  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    if (clr) begin
      active_d = 1'b0;
      idx_d    = '0;
      mask_d   = '0;
    end else if (start) begin
      active_d = 1'b1;
      idx_d    = '0;
      mask_d   = '0;
    end else if (active_q) begin
      mask_d = mask;
      if (done) begin
        active_d = 1'b0;
        idx_d    = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      mask_q   <= '0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
    end
  end

endmodule

// File: rtl/hangman_engine.sv
// Hangman game engine: holds a secret word, scans each accepted guess one
// letter per cycle, then reports hit / miss / repeat and tracks win / lose.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   word_in, word_load       - secret word and load strobe (IDLE only)
//   new_game                 - synchronous abort to IDLE, overrides all
//   guess, guess_valid       - guess handshake; guess_ready accepts
//   revealed, hits, mistakes - uncovered letters, their count, misses
//   last_hit/last_miss/repeat_guess - one-cycle verdicts during UPDATE
//   win, lose                - terminal levels
//   busy, game_rdy           - SCAN/UPDATE active, engine in IDLE
module hangman_engine
  import hangman_pkg::*;
#(
  parameter int unsigned WORD_LEN     = WORD_LEN_DEF,
  parameter int unsigned MAX_MISTAKES = MAX_MISTAKES_DEF,
  parameter int unsigned CHAR_W       = CHAR_W_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WORD_LEN*CHAR_W-1:0]         word_in,
  input  logic                               word_load,
  input  logic                               new_game,
  input  logic [CHAR_W-1:0]                  guess,
  input  logic                               guess_valid,
  output logic                               guess_ready,
  output logic [WORD_LEN-1:0]                revealed,
  output logic [$clog2(WORD_LEN+1)-1:0]      hits,
  output logic [$clog2(MAX_MISTAKES+1)-1:0]  mistakes,
  output logic                               last_hit,
  output logic                               last_miss,
  output logic                               repeat_guess,
  output logic                               win,
  output logic                               lose,
  output logic                               busy,
  output logic                               game_rdy
);

  localparam int unsigned HIT_W  = $clog2(WORD_LEN + 1);
  localparam int unsigned MIS_W  = $clog2(MAX_MISTAKES + 1);
  localparam int unsigned USED_N = 1 << CHAR_W;

  state_t                      state_q, state_d;
  logic [WORD_LEN*CHAR_W-1:0]  word_q, word_d;
  logic [CHAR_W-1:0]           guess_q, guess_d;
  logic [WORD_LEN-1:0]         revealed_q, revealed_d;
  logic [MIS_W-1:0]            mistakes_q, mistakes_d;
  logic [USED_N-1:0]           used_q, used_d;
  logic                        hit_q, hit_d, miss_q, miss_d, rep_q, rep_d;
  logic                        guess_ready_q, guess_ready_d;
  logic                        busy_q, busy_d;
  logic                        game_rdy_q, game_rdy_d;
  logic                        win_q, win_d, lose_q, lose_d;
  logic [WORD_LEN-1:0]         pad_c;
  logic [HIT_W-1:0]            hits_c;
  logic                        scan_start_c, scan_done;
  logic [WORD_LEN-1:0]         scan_mask;

  assign scan_start_c = (state_q == ST_WAIT_GUESS) && guess_valid && !new_game;

  letter_scanner #(
    .WORD_LEN (WORD_LEN),
    .CHAR_W   (CHAR_W)
  ) u_scanner (
    .clk   (clk),
    .rst   (rst),
    .clr   (new_game),
    .start (scan_start_c),
    .word  (word_q),
    .guess (guess_q),
    .done  (scan_done),
    .mask  (scan_mask)
  );

  // Zero (padding) letters of the incoming word are revealed at load.
  always_comb begin
    pad_c = '0;
    for (int i = 0; i < int'(WORD_LEN); i++) begin
      pad_c[i] = (word_in[(int'(WORD_LEN) - 1 - i) * int'(CHAR_W) +: CHAR_W] == '0);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; new_game wins over everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (word_load)   state_d = ST_WAIT_GUESS;
      ST_WAIT_GUESS: if (guess_valid) state_d = ST_SCAN;
      ST_SCAN:       if (scan_done)   state_d = ST_UPDATE;
      ST_UPDATE: begin
        if (&revealed_q)                              state_d = ST_WIN;
        else if (mistakes_q == MIS_W'(MAX_MISTAKES))  state_d = ST_LOSE;
        else                                          state_d = ST_WAIT_GUESS;
      end
      ST_WIN:        state_d = ST_WIN;
      ST_LOSE:       state_d = ST_LOSE;
      default:       state_d = ST_IDLE;
    endcase
    if (new_game) state_d = ST_IDLE;
  end

  // Status outputs decoded from the next state so they register in step
  // with the state register.
  always_comb begin
    guess_ready_d = (state_d == ST_WAIT_GUESS);
    busy_d        = (state_d == ST_SCAN) || (state_d == ST_UPDATE);
    game_rdy_d    = (state_d == ST_IDLE);
    win_d         = (state_d == ST_WIN);
    lose_d        = (state_d == ST_LOSE);
  end

  // Game datapath. The verdict is resolved on the last scan cycle so the
  // pulse and the updated counters are both visible during UPDATE.
  always_comb begin
    word_d     = word_q;
    guess_d    = guess_q;
    revealed_d = revealed_q;
    mistakes_d = mistakes_q;
    used_d     = used_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    rep_d      = 1'b0;
    if (new_game) begin
      revealed_d = '0;
      mistakes_d = '0;
      used_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (word_load) begin
            word_d     = word_in;
            revealed_d = pad_c;
            mistakes_d = '0;
            used_d     = '0;
          end
        end
        ST_WAIT_GUESS: begin
          if (guess_valid) guess_d = guess;
        end
        ST_SCAN: begin
          if (scan_done) begin
            if (used_q[guess_q]) begin
              rep_d = 1'b1;
            end else if (|(scan_mask & ~revealed_q)) begin
              hit_d      = 1'b1;
              revealed_d = revealed_q | scan_mask;
            end else begin
              miss_d = 1'b1;
              if (mistakes_q < MIS_W'(MAX_MISTAKES)) mistakes_d = mistakes_q + MIS_W'(1);
            end
            used_d[guess_q] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q        <= '0;
      guess_q       <= '0;
      revealed_q    <= '0;
      mistakes_q    <= '0;
      used_q        <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      rep_q         <= 1'b0;
      guess_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      game_rdy_q    <= 1'b1;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      word_q        <= word_d;
      guess_q       <= guess_d;
      revealed_q    <= revealed_d;
      mistakes_q    <= mistakes_d;
      used_q        <= used_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      rep_q         <= rep_d;
      guess_ready_q <= guess_ready_d;
      busy_q        <= busy_d;
      game_rdy_q    <= game_rdy_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
    end
  end

  // Popcount of the revealed mask.
  always_comb begin
    hits_c = '0;
    for (int i = 0; i < int'(WORD_LEN); i++) begin
      hits_c = hits_c + HIT_W'(revealed_q[i]);
    end
  end

  assign guess_ready  = guess_ready_q;
  assign revealed     = revealed_q;
  assign hits         = hits_c;
  assign mistakes     = mistakes_q;
  assign last_hit     = hit_q;
  assign last_miss    = miss_q;
  assign repeat_guess = rep_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign busy         = busy_q;
  assign game_rdy     = game_rdy_q;

endmodule

// File: tb/tb_hangman_engine.sv
// Self-checking bench for hangman_engine: directed game scenarios plus
// randomized games compared against a letter-level model of the rules.
module tb_hangman_engine;

  localparam int unsigned WL = 5;
  localparam int unsigned MM = 6;
  localparam int unsigned CW = 8;
  localparam logic [39:0] HELLO = 40'h48454C4C4F;
  localparam logic [39:0] CAT   = 40'h4341540000;

  logic          clk = 1'b0;
  logic          rst;
  logic [39:0]   word_in;
  logic          word_load, new_game, guess_valid;
  logic [7:0]    guess;
  logic          guess_ready, last_hit, last_miss, repeat_guess;
  logic          win, lose, busy, game_rdy;
  logic [4:0]    revealed;
  logic [2:0]    hits, mistakes;

  int vectors = 0;
  int miscompares = 0;

  // Model state: the word as letters, uncovered letters, guessed set, misses.
  logic [7:0]    m_letter [WL];
  logic [WL-1:0] m_rev;
  bit   [255:0]  m_used;
  int            m_mis;
  bit            m_over;

  hangman_engine #(.WORD_LEN(WL), .MAX_MISTAKES(MM), .CHAR_W(CW)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_load(word_load),
    .new_game(new_game), .guess(guess), .guess_valid(guess_valid),
    .guess_ready(guess_ready), .revealed(revealed), .hits(hits),
    .mistakes(mistakes), .last_hit(last_hit), .last_miss(last_miss),
    .repeat_guess(repeat_guess), .win(win), .lose(lose), .busy(busy),
    .game_rdy(game_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int popc(input logic [WL-1:0] v);
    int n = 0;
    for (int i = 0; i < int'(WL); i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_clear();
    m_rev = '0; m_used = '0; m_mis = 0; m_over = 1'b0;
  endtask

  task automatic model_load(input logic [39:0] w);
    model_clear();
    for (int i = 0; i < int'(WL); i++) begin
      m_letter[i] = w[(int'(WL) - 1 - i) * 8 +: 8];
      m_rev[i]    = (m_letter[i] == 8'h00);
    end
  endtask

  // Returns verdict: 0 repeat, 1 hit, 2 miss.
  task automatic model_guess(input logic [7:0] g, output int verdict);
    logic [WL-1:0] fresh;
    fresh = '0;
    if (m_used[g]) verdict = 0;
    else begin
      for (int i = 0; i < int'(WL); i++)
        if (m_letter[i] == g && !m_rev[i]) fresh[i] = 1'b1;
      if (fresh != 0) begin
        verdict = 1;
        m_rev |= fresh;
      end else begin
        verdict = 2;
        if (m_mis < int'(MM)) m_mis++;
      end
    end
    m_used[g] = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; word_in = '0; word_load = 0; new_game = 0; guess = '0; guess_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_clear();
  endtask

  task automatic load_word(input logic [39:0] w);
    @(negedge clk);
    word_in = w; word_load = 1'b1;
    @(posedge clk); #1;
    word_load = 1'b0;
    model_load(w);
    vectors++;
    if ({game_rdy, guess_ready, revealed} !== {1'b0, 1'b1, m_rev}) begin
      miscompares++;
      $display("FAIL load: rdy/ready/revealed got %b/%b/%b want 0/1/%b",
               game_rdy, guess_ready, revealed, m_rev);
    end
  endtask

  task automatic pulse_new_game();
    @(negedge clk) new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_clear();
    vectors++;
    if ({game_rdy, guess_ready, busy, win, lose, revealed, hits, mistakes} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 3'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL new_game_clear: rdy=%b rdy_g=%b busy=%b win=%b lose=%b rev=%b hits=%0d mis=%0d",
               game_rdy, guess_ready, busy, win, lose, revealed, hits, mistakes);
    end
  endtask

  // Offers one guess and checks the whole transaction against the model.
  task automatic play_guess(input logic [7:0] g);
    int verdict, waited;
    logic [2:0] exp_p;
    bit exp_win, exp_lose;
    waited = 0;
    while (guess_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    vectors++;
    if (guess_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout: guess_ready=%b want 1", guess_ready);
      return;
    end
    @(negedge clk);
    guess = g; guess_valid = 1'b1;
    model_guess(g, verdict);
    exp_p = (verdict == 1) ? 3'b100 : (verdict == 2) ? 3'b010 : 3'b001;
    @(posedge clk); #1;
    guess_valid = 1'b0;
    guess = 8'($urandom);
    for (int k = 0; k < int'(WL); k++) begin
      vectors++;
      if ({busy, guess_ready, last_hit, last_miss, repeat_guess} !== 5'b10000) begin
        miscompares++;
        $display("FAIL scan_quiet[%0d] '%c': busy/ready/hit/miss/rep got %b want 10000",
                 k, g, {busy, guess_ready, last_hit, last_miss, repeat_guess});
      end
      @(posedge clk); #1;
    end
    vectors++;
    if ({last_hit, last_miss, repeat_guess} !== exp_p) begin
      miscompares++;
      $display("FAIL verdict '%c': hit/miss/rep got %b want %b", g,
               {last_hit, last_miss, repeat_guess}, exp_p);
    end
    vectors++;
    if ({revealed, hits, mistakes, busy} !== {m_rev, 3'(popc(m_rev)), 3'(m_mis), 1'b1}) begin
      miscompares++;
      $display("FAIL update_state '%c': rev=%b hits=%0d mis=%0d busy=%b want %b %0d %0d 1",
               g, revealed, hits, mistakes, busy, m_rev, popc(m_rev), m_mis);
    end
    exp_win  = (m_rev == '1);
    exp_lose = !exp_win && (m_mis == int'(MM));
    m_over   = exp_win || exp_lose;
    @(posedge clk); #1;
    vectors++;
    if ({win, lose, guess_ready, busy, last_hit, last_miss, repeat_guess} !==
        {exp_win, exp_lose, !(exp_win || exp_lose), 4'b0000}) begin
      miscompares++;
      $display("FAIL after_update '%c': win=%b lose=%b ready=%b busy=%b pulses=%b want %b %b %b 0 000",
               g, win, lose, guess_ready, busy, {last_hit, last_miss, repeat_guess},
               exp_win, exp_lose, !(exp_win || exp_lose));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; word_in = '0; word_load = 0; new_game = 0; guess = '0; guess_valid = 0;
    #1;
    vectors++;
    if ({guess_ready, busy, game_rdy, win, lose, last_hit, last_miss, repeat_guess,
         revealed, hits, mistakes} !== {8'b00100000, 5'b0, 3'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_values: got rdy=%b busy=%b grdy=%b win=%b lose=%b rev=%b hits=%0d mis=%0d",
               guess_ready, busy, game_rdy, win, lose, revealed, hits, mistakes);
    end
    apply_reset();
  endtask

  task automatic test_hit_and_repeat();
    load_word(HELLO);
    play_guess("L");
    vectors++;
    if ({revealed, hits, mistakes} !== {5'b01100, 3'd2, 3'd0}) begin
      miscompares++;
      $display("FAIL hello_L: rev=%b hits=%0d mis=%0d want 01100 2 0", revealed, hits, mistakes);
    end
    play_guess("L");
    vectors++;
    if ({revealed, mistakes} !== {5'b01100, 3'd0}) begin
      miscompares++;
      $display("FAIL repeat_L: rev=%b mis=%0d want 01100 0", revealed, mistakes);
    end
  endtask

  task automatic test_lose();
    logic [7:0] seq [6] = '{"A", "B", "C", "D", "F", "G"};
    foreach (seq[i]) play_guess(seq[i]);
    vectors++;
    if ({lose, win, guess_ready, mistakes} !== {1'b1, 1'b0, 1'b0, 3'd6}) begin
      miscompares++;
      $display("FAIL lose_state: lose=%b win=%b ready=%b mis=%0d want 1 0 0 6",
               lose, win, guess_ready, mistakes);
    end
    // Guesses offered in LOSE must be ignored.
    @(negedge clk) guess = "H"; guess_valid = 1'b1;
    repeat (WL + 3) @(posedge clk);
    #1 guess_valid = 1'b0;
    vectors++;
    if ({lose, busy, revealed, mistakes} !== {1'b1, 1'b0, 5'b01100, 3'd6}) begin
      miscompares++;
      $display("FAIL lose_hold: lose=%b busy=%b rev=%b mis=%0d want 1 0 01100 6",
               lose, busy, revealed, mistakes);
    end
    pulse_new_game();
  endtask

  task automatic test_win();
    load_word(HELLO);
    play_guess("H"); play_guess("E"); play_guess("L"); play_guess("O");
    vectors++;
    if ({win, lose, hits, guess_ready} !== {1'b1, 1'b0, 3'd5, 1'b0}) begin
      miscompares++;
      $display("FAIL win_state: win=%b lose=%b hits=%0d ready=%b want 1 0 5 0",
               win, lose, hits, guess_ready);
    end
    pulse_new_game();
  endtask

  task automatic test_padded_word();
    load_word(CAT);
    vectors++;
    if (revealed !== 5'b11000) begin
      miscompares++;
      $display("FAIL cat_pad: rev=%b want 11000", revealed);
    end
    play_guess("C"); play_guess("A"); play_guess("T");
    vectors++;
    if ({win, hits} !== {1'b1, 3'd5}) begin
      miscompares++;
      $display("FAIL cat_win: win=%b hits=%0d want 1 5", win, hits);
    end
    pulse_new_game();
  endtask

  task automatic test_rst_mid_scan();
    bit stray;
    load_word(HELLO);
    @(negedge clk) guess = "Z"; guess_valid = 1'b1;
    @(posedge clk); #1 guess_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    vectors++;
    if ({guess_ready, busy, game_rdy, win, lose, last_hit, last_miss, repeat_guess,
         revealed, hits, mistakes} !== {8'b00100000, 5'b0, 3'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL rst_mid_scan: rdy=%b busy=%b grdy=%b rev=%b mis=%0d want 0 0 1 0 0",
               guess_ready, busy, game_rdy, revealed, mistakes);
    end
    @(negedge clk) rst = 1'b0;
    model_clear();
    stray = 1'b0;
    repeat (WL + 3) begin
      @(posedge clk); #1;
      if (last_hit || last_miss || repeat_guess || busy || mistakes != 0) stray = 1'b1;
    end
    vectors++;
    if (stray !== 1'b0 || game_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_abandon: stray=%b game_rdy=%b want 0 1", stray, game_rdy);
    end
    load_word(HELLO);
    play_guess("Z");
    pulse_new_game();
  endtask

  task automatic test_newgame_vs_guess();
    bit stray;
    load_word(HELLO);
    @(negedge clk) new_game = 1'b1; guess_valid = 1'b1; guess = "H";
    @(posedge clk); #1 new_game = 1'b0; guess_valid = 1'b0;
    model_clear();
    stray = 1'b0;
    repeat (WL + 3) begin
      if (last_hit || last_miss || repeat_guess || busy || revealed != 0) stray = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if ({stray, game_rdy, guess_ready} !== 3'b010) begin
      miscompares++;
      $display("FAIL newgame_drop: stray=%b game_rdy=%b ready=%b want 0 1 0",
               stray, game_rdy, guess_ready);
    end
  endtask

  task automatic test_load_ignored();
    load_word(HELLO);
    @(negedge clk) word_in = 40'h5858585858; word_load = 1'b1;
    @(posedge clk); #1 word_load = 1'b0;
    vectors++;
    if ({game_rdy, guess_ready, revealed} !== {1'b0, 1'b1, 5'b0}) begin
      miscompares++;
      $display("FAIL load_ignored: grdy=%b ready=%b rev=%b want 0 1 00000",
               game_rdy, guess_ready, revealed);
    end
    play_guess("H");
    play_guess("X");
    pulse_new_game();
  endtask

  task automatic test_random_games();
    logic [39:0] w;
    int n;
    for (int game = 0; game < 8; game++) begin
      for (int i = 0; i < int'(WL); i++)
        w[i*8 +: 8] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'(8'h41 + $urandom_range(0, 5));
      load_word(w);
      n = 0;
      while (!m_over && n < 30) begin
        play_guess(8'(8'h41 + $urandom_range(0, 7)));
        n++;
      end
      pulse_new_game();
    end
  endtask

  initial begin
    test_reset();
    test_hit_and_repeat();
    test_lose();
    test_win();
    test_padded_word();
    test_rst_mid_scan();
    test_newgame_vs_guess();
    test_load_ignored();
    test_random_games();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
